// File: rtl/axis_mux_pkg.sv
// axis_mux_pkg
//   Shared types and helpers for the AXI4-Stream packet multiplexer.
//   - mux_state_e : arbiter states (IDLE, LOCK)
//   - clog2_min1  : $clog2 clamped to at least 1 bit
//   - rr_pick     : round-robin winner search starting at ptr+1
package axis_mux_pkg;

    // Upper bound on channel count accepted by rr_pick's valid vector.
    localparam int MAX_NCH = 64;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } mux_state_e;

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // First set bit of valid[0..n-1] searched from ptr+1 upward, wrapping.
    // ptr itself is visited last, so the previous winner has lowest priority.
    function automatic int rr_pick(input logic [MAX_NCH-1:0] valid,
                                   input int ptr, input int n);
        int   idx;
        int   win;
        logic found;
        win   = 0;
        found = 1'b0;
        for (int k = 1; k <= n; k++) begin
            idx = ptr + k;
            if (idx >= n) idx = idx - n;
            if (!found && valid[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// axis_skid_buffer
//   Two-entry output buffer with registered outputs. The producer must only
//   push while o_full is low; pop happens on o_valid && i_ready.
//   Ports:
//     i_clk, i_rst (sync, active-high), i_en (clock enable)
//     i_push, i_data  : write side
//     i_ready         : downstream ready
//     o_valid, o_data : read side (head entry)
//     o_full          : both entries occupied
module axis_skid_buffer #(
    parameter int PW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_en,
    input  logic          i_push,
    input  logic [PW-1:0] i_data,
    input  logic          i_ready,
    output logic          o_valid,
    output logic [PW-1:0] o_data,
    output logic          o_full
);

    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [1:0]    r_cnt;
    logic          w_pop;

    assign w_pop   = (r_cnt != 2'd0) && i_ready;
    assign o_valid = (r_cnt != 2'd0);
    assign o_full  = (r_cnt == 2'd2);
    assign o_data  = r_head;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= 2'd0;
        end else if (i_en) begin
            case ({i_push, w_pop})
                2'b11: begin
                    // Count unchanged; the new beat lands behind whatever remains.
                    if (r_cnt == 2'd1) begin
                        r_head <= i_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_data;
                    end
                end
                2'b10: begin
                    if (r_cnt == 2'd0) r_head <= i_data;
                    else               r_tail <= i_data;
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    // Draining the last entry leaves the head value in place.
                    if (r_cnt == 2'd2) r_head <= r_tail;
                    r_cnt <= r_cnt - 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/axis_packet_mux.sv
// axis_packet_mux
//   NCH-channel AXI4-Stream packet multiplexer, round-robin at packet
//   granularity, with a 2-entry registered output buffer.
//   Ports:
//     aclk, areset (sync, active-high), aclken (clock enable)
//     s_axi_*      : NCH slave streams, channel i at [i*W +: W]
//     m_axi_*      : merged master stream (registered)
//     grant_active : a packet is locked
//     grant_idx    : currently or last granted channel
//     m_axi_tid    : source channel of the output beat (AXIS_MUX_TID_EN only)
//   Optional build macro: AXIS_MUX_TID_EN.
module axis_packet_mux
    import axis_mux_pkg::*;
#(
    parameter  int NCH   = 4,
    parameter  int DSIZE = 32,
    parameter  int USIZE = 1,
    localparam int CHW   = clog2_min1(NCH)
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   aclken,
    input  logic [NCH*DSIZE-1:0]   s_axi_tdata,
    input  logic [NCH*USIZE-1:0]   s_axi_tuser,
    input  logic [NCH-1:0]         s_axi_tvalid,
    input  logic [NCH-1:0]         s_axi_tlast,
    output logic [NCH-1:0]         s_axi_tready,
    output logic [DSIZE-1:0]       m_axi_tdata,
    output logic [USIZE-1:0]       m_axi_tuser,
    output logic                   m_axi_tvalid,
    output logic                   m_axi_tlast,
    input  logic                   m_axi_tready,
`ifdef AXIS_MUX_TID_EN
    output logic [CHW-1:0]         m_axi_tid,
`endif
    output logic                   grant_active,
    output logic [CHW-1:0]         grant_idx
);

`ifdef AXIS_MUX_TID_EN
    localparam int PW = USIZE + 1 + DSIZE + CHW;
`else
    localparam int PW = USIZE + 1 + DSIZE;
`endif

    mux_state_e     r_state, w_state_nxt;
    logic [CHW-1:0] r_ptr, w_ptr_nxt;
    logic [CHW-1:0] r_grant, w_grant_nxt;
    logic [CHW-1:0] w_win;
    logic           w_skid_full;
    logic           w_rdy;
    logic           w_accept;
    logic [DSIZE-1:0] w_data;
    logic [USIZE-1:0] w_user;
    logic           w_last;
    logic [PW-1:0]  w_push_data;
    logic [PW-1:0]  w_out_data;

    assign w_win  = CHW'(rr_pick(MAX_NCH'(s_axi_tvalid), int'(r_ptr), NCH));
    assign w_data = s_axi_tdata[r_grant*DSIZE +: DSIZE];
    assign w_user = s_axi_tuser[r_grant*USIZE +: USIZE];
    assign w_last = s_axi_tlast[r_grant];
    // Ready only looks at registered state plus the enable/reset qualifiers.
    assign w_rdy  = aclken && !areset && !w_skid_full;

    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_grant_nxt  = r_grant;
        s_axi_tready = '0;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (|s_axi_tvalid) begin
                    w_grant_nxt = w_win;
                    w_state_nxt = LOCK;
                end
            end
            LOCK: begin
                s_axi_tready[r_grant] = w_rdy;
                w_accept = s_axi_tvalid[r_grant] && w_rdy;
                if (w_accept && w_last) begin
                    w_state_nxt = IDLE;
                    w_ptr_nxt   = r_grant;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= IDLE;
            r_ptr   <= CHW'(NCH - 1);
            r_grant <= '0;
        end else if (aclken) begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_grant <= w_grant_nxt;
        end
    end

    assign grant_active = (r_state == LOCK);
    assign grant_idx    = r_grant;

`ifdef AXIS_MUX_TID_EN
    assign w_push_data = {w_user, w_last, w_data, r_grant};
    assign {m_axi_tuser, m_axi_tlast, m_axi_tdata, m_axi_tid} = w_out_data;
`else
    assign w_push_data = {w_user, w_last, w_data};
    assign {m_axi_tuser, m_axi_tlast, m_axi_tdata} = w_out_data;
`endif

    axis_skid_buffer #(
        .PW (PW)
    ) u_skid (
        .i_clk   (aclk),
        .i_rst   (areset),
        .i_en    (aclken),
        .i_push  (w_accept),
        .i_data  (w_push_data),
        .i_ready (m_axi_tready),
        .o_valid (m_axi_tvalid),
        .o_data  (w_out_data),
        .o_full  (w_skid_full)
    );

endmodule

// File: tb/tb_axis_packet_mux.sv
// tb_axis_packet_mux
//   Directed bench for axis_packet_mux (NCH=4). Accepted slave beats are
//   pushed to a scoreboard and compared in order against master beats.
//   Define AXIS_MUX_TID_EN to also compare m_axi_tid.
module tb_axis_packet_mux;

    localparam int NCH   = 4;
    localparam int DSIZE = 32;
    localparam int USIZE = 1;
    localparam int CHW   = 2;

    logic                 aclk = 1'b0;
    logic                 areset;
    logic                 aclken;
    logic [NCH*DSIZE-1:0] s_axi_tdata;
    logic [NCH*USIZE-1:0] s_axi_tuser;
    logic [NCH-1:0]       s_axi_tvalid;
    logic [NCH-1:0]       s_axi_tlast;
    logic [NCH-1:0]       s_axi_tready;
    logic [DSIZE-1:0]     m_axi_tdata;
    logic [USIZE-1:0]     m_axi_tuser;
    logic                 m_axi_tvalid;
    logic                 m_axi_tlast;
    logic                 m_axi_tready;
`ifdef AXIS_MUX_TID_EN
    logic [CHW-1:0]       m_axi_tid;
`endif
    logic                 grant_active;
    logic [CHW-1:0]       grant_idx;

    axis_packet_mux #(.NCH(NCH), .DSIZE(DSIZE), .USIZE(USIZE)) dut (
        .aclk         (aclk),
        .areset       (areset),
        .aclken       (aclken),
        .s_axi_tdata  (s_axi_tdata),
        .s_axi_tuser  (s_axi_tuser),
        .s_axi_tvalid (s_axi_tvalid),
        .s_axi_tlast  (s_axi_tlast),
        .s_axi_tready (s_axi_tready),
        .m_axi_tdata  (m_axi_tdata),
        .m_axi_tuser  (m_axi_tuser),
        .m_axi_tvalid (m_axi_tvalid),
        .m_axi_tlast  (m_axi_tlast),
        .m_axi_tready (m_axi_tready),
`ifdef AXIS_MUX_TID_EN
        .m_axi_tid    (m_axi_tid),
`endif
        .grant_active (grant_active),
        .grant_idx    (grant_idx)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [DSIZE-1:0] d;
        logic [USIZE-1:0] u;
        logic             l;
        logic [CHW-1:0]   ch;
    } beat_t;

    beat_t    src_q[NCH][$];
    beat_t    sb_q[$];
    beat_t    exp_b;
    logic [NCH-1:0] en_v;
    int       cyc;
    int       acc_cyc[$];
    bit       acc_last[$];
    int       out_ch[$];
    bit       watch_r1;
    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic void add_pkt(input int ch, input int id, input int len);
        for (int b = 0; b < len; b++) begin
            beat_t x;
            x.d  = {8'(ch), 8'(id), 16'(b)};
            x.u  = USIZE'(b & 1);
            x.l  = (b == len - 1);
            x.ch = CHW'(ch);
            src_q[ch].push_back(x);
        end
    endfunction

    function automatic void drive();
        for (int c = 0; c < NCH; c++) begin
            if (en_v[c] && src_q[c].size() > 0) begin
                s_axi_tvalid[c]                   = 1'b1;
                s_axi_tdata[c*DSIZE +: DSIZE]     = src_q[c][0].d;
                s_axi_tuser[c*USIZE +: USIZE]     = src_q[c][0].u;
                s_axi_tlast[c]                    = src_q[c][0].l;
            end else begin
                s_axi_tvalid[c] = 1'b0;
                s_axi_tlast[c]  = 1'b0;
            end
        end
    endfunction

    // One clock: sample handshakes at negedge, retire accepted beats after posedge.
    task automatic tick();
        logic [NCH-1:0] acc;
        @(negedge aclk);
        acc = (aclken && !areset) ? (s_axi_tvalid & s_axi_tready) : '0;
        if (watch_r1) check("lock_rdy1", 64'(s_axi_tready[1]), 64'd0);
        @(posedge aclk);
        #1;
        cyc++;
        for (int c = 0; c < NCH; c++) begin
            if (acc[c]) begin
                sb_q.push_back(src_q[c][0]);
                acc_cyc.push_back(cyc);
                acc_last.push_back(src_q[c][0].l);
                void'(src_q[c].pop_front());
            end
        end
        drive();
    endtask

    function automatic bit busy();
        bit b;
        b = (sb_q.size() != 0) || m_axi_tvalid || grant_active;
        for (int c = 0; c < NCH; c++) if (src_q[c].size() != 0) b = 1'b1;
        return b;
    endfunction

    task automatic run_idle(input string tag);
        int n;
        n = 0;
        while (busy() && n < 300) begin
            tick();
            n++;
        end
        check({tag, "_drained"}, 64'(busy()), 64'd0);
    endtask

    task automatic clear_logs();
        acc_cyc.delete();
        acc_last.delete();
        out_ch.delete();
    endtask

    // Output monitor / scoreboard compare.
    always @(negedge aclk) begin
        if (!areset && aclken && m_axi_tvalid === 1'b1 && m_axi_tready) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 64'd1, 64'd0);
            end else begin
                exp_b = sb_q.pop_front();
                check("out_data", 64'(m_axi_tdata), 64'(exp_b.d));
                check("out_user", 64'(m_axi_tuser), 64'(exp_b.u));
                check("out_last", 64'(m_axi_tlast), 64'(exp_b.l));
`ifdef AXIS_MUX_TID_EN
                check("out_tid", 64'(m_axi_tid), 64'(exp_b.ch));
`endif
                out_ch.push_back(int'(m_axi_tdata[31:24]));
            end
        end
    end

    initial begin
        int exp_rr[5];
        int first_ch[$];
        int ch_seq[7];
        int ch_tid[5];
        exp_rr = '{0, 1, 2, 3, 0};
        ch_seq = '{2, 2, 2, 2, 2, 1, 1};
        ch_tid = '{1, 1, 1, 3, 3};
        cyc = 0;
        watch_r1 = 1'b0;
        s_axi_tdata = '0;
        s_axi_tuser = '0;
        s_axi_tvalid = '0;
        s_axi_tlast = '0;
        m_axi_tready = 1'b1;
        aclken = 1'b1;
        areset = 1'b1;

        // Reset with all channels valid.
        add_pkt(0, 1, 2);
        add_pkt(1, 2, 2);
        add_pkt(2, 3, 2);
        add_pkt(3, 4, 2);
        add_pkt(0, 5, 2);
        en_v = '1;
        drive();
        repeat (3) begin
            tick();
            check("rst_m_valid", 64'(m_axi_tvalid), 64'd0);
            check("rst_m_last",  64'(m_axi_tlast),  64'd0);
            check("rst_m_data",  64'(m_axi_tdata),  64'd0);
            check("rst_m_user",  64'(m_axi_tuser),  64'd0);
            check("rst_s_ready", 64'(s_axi_tready), 64'd0);
            check("rst_gnt_act", 64'(grant_active), 64'd0);
            check("rst_gnt_idx", 64'(grant_idx),    64'd0);
`ifdef AXIS_MUX_TID_EN
            check("rst_m_tid",   64'(m_axi_tid),    64'd0);
`endif
        end
        areset = 1'b0;
        tick();
        check("first_gnt_act", 64'(grant_active), 64'd1);
        check("first_gnt_idx", 64'(grant_idx),    64'd0);

        // Round-robin across 4 continuously valid channels.
        run_idle("rr");
        for (int i = 0; i < out_ch.size(); i++)
            if (i == 0 || (i % 2) == 0) first_ch.push_back(out_ch[i]);
        check("rr_npkts", 64'(first_ch.size()), 64'd5);
        for (int i = 0; i < 5 && i < first_ch.size(); i++)
            check("rr_order", 64'(first_ch[i]), 64'(exp_rr[i]));
        check("rr_naccept", 64'(acc_cyc.size()), 64'd10);
        for (int i = 1; i < acc_cyc.size(); i++)
            check("rr_gap", 64'(acc_cyc[i] - acc_cyc[i-1]), acc_last[i-1] ? 64'd2 : 64'd1);
        clear_logs();

        // Packet lock: channel 2 stalls mid-packet while channel 1 waits.
        add_pkt(2, 6, 5);
        add_pkt(1, 7, 2);
        en_v = 4'b0100;
        drive();
        for (int n = 0; n < 50 && src_q[2].size() > 3; n++) tick();
        check("lock_two_beats", 64'(src_q[2].size()), 64'd3);
        en_v = 4'b0010;
        drive();
        watch_r1 = 1'b1;
        repeat (4) tick();
        check("lock_hold_gnt", 64'(grant_idx), 64'd2);
        en_v = 4'b0110;
        drive();
        for (int n = 0; n < 50 && src_q[2].size() > 0; n++) tick();
        watch_r1 = 1'b0;
        run_idle("lock");
        check("lock_nbeats", 64'(out_ch.size()), 64'd7);
        for (int i = 0; i < 7 && i < out_ch.size(); i++)
            check("lock_order", 64'(out_ch[i]), 64'(ch_seq[i]));
        clear_logs();

        // Backpressure: master stalls for 10 cycles mid-packet.
        add_pkt(3, 8, 8);
        en_v = 4'b1000;
        drive();
        for (int n = 0; n < 50 && src_q[3].size() > 5; n++) tick();
        m_axi_tready = 1'b0;
        repeat (10) tick();
        check("bp_buffered", 64'(sb_q.size()), 64'd2);
        check("bp_src_left", 64'(src_q[3].size()), 64'd4);
        check("bp_s_ready",  64'(s_axi_tready), 64'd0);
        check("bp_m_valid",  64'(m_axi_tvalid), 64'd1);
        if (sb_q.size() != 0) check("bp_m_data", 64'(m_axi_tdata), 64'(sb_q[0].d));
        m_axi_tready = 1'b1;
        run_idle("bp");
        check("bp_nbeats", 64'(out_ch.size()), 64'd8);
        clear_logs();

        // Clock enable low for 3 cycles mid-packet.
        add_pkt(0, 9, 4);
        en_v = 4'b0001;
        drive();
        for (int n = 0; n < 50 && src_q[0].size() > 2; n++) tick();
        aclken = 1'b0;
        repeat (3) begin
            tick();
            check("ce_s_ready",  64'(s_axi_tready), 64'd0);
            check("ce_m_valid",  64'(m_axi_tvalid), 64'd1);
            if (sb_q.size() != 0) check("ce_m_data", 64'(m_axi_tdata), 64'(sb_q[0].d));
            check("ce_src_left", 64'(src_q[0].size()), 64'd2);
            check("ce_gnt_act",  64'(grant_active), 64'd1);
        end
        aclken = 1'b1;
        run_idle("ce");
        check("ce_nbeats", 64'(out_ch.size()), 64'd4);
        clear_logs();

        // Channels 3 and 1 compete; tid (when built) follows each packet.
        add_pkt(3, 10, 2);
        add_pkt(1, 11, 3);
        en_v = 4'b1010;
        drive();
        run_idle("tid");
        check("tid_nbeats", 64'(out_ch.size()), 64'd5);
        for (int i = 0; i < 5 && i < out_ch.size(); i++)
            check("tid_order", 64'(out_ch[i]), 64'(ch_tid[i]));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/axis_packet_mux.md
# axis_packet_mux

N-channel AXI4-Stream packet multiplexer for the stream fabric. Merges `NCH` slave streams onto one master stream with round-robin arbitration at packet granularity: the grant locks on the first beat and releases only after the beat carrying `tlast` is accepted. The output is buffered, so the block runs at full throughput and isolates `m_axi_tready` timing from the slave side. It sits between stream producers, such as DMA channels or per-port framers, and a single stream consumer.

## Interface
Parameters:
- `NCH`, 4, number of slave channels (≥1)
- `DSIZE`, 32, tdata width in bits
- `USIZE`, 1, tuser width in bits
- `CHW`, derived localparam, max(1, $clog2(NCH)); not overridable

Ports:
- `aclk` in 1: clock; single clock domain
- `areset` in 1: reset, synchronous, active-high
- `aclken` in 1: clock enable; low freezes all state
- `s_axi_tdata` in NCH*DSIZE: channel i occupies bits [i*DSIZE +: DSIZE]
- `s_axi_tuser` in NCH*USIZE: channel i occupies bits [i*USIZE +: USIZE]
- `s_axi_tvalid` in NCH: per-channel valid
- `s_axi_tlast` in NCH: per-channel last
- `s_axi_tready` out NCH: per-channel ready
- `m_axi_tdata` out DSIZE
- `m_axi_tuser` out USIZE
- `m_axi_tvalid` out 1
- `m_axi_tlast` out 1
- `m_axi_tready` in 1
- `grant_active` out 1: high while a packet is locked
- `grant_idx` out CHW: currently or last granted channel
- `m_axi_tid` out CHW: source channel of the current output beat; present only with `AXIS_MUX_TID_EN`

## Operation
- Arbiter FSM states: IDLE, LOCK.
- IDLE:
  - All `s_axi_tready` are 0.
  - If any `s_axi_tvalid` is high, the winner is the first valid channel searched from `ptr+1` upward, modulo NCH.
  - On the next edge, `grant_idx` takes the winner, the FSM moves to LOCK, and `grant_active` goes to 1.
- LOCK:
  - `s_axi_tready[grant_idx] = !skid_full`. All other readies are 0.
  - A slave beat is accepted when valid && ready.
  - On an accepted beat with `tlast`=1, the FSM returns to IDLE, `ptr` takes `grant_idx`, and `grant_active` goes to 0.
  - The grant holds while the granted channel's valid is low mid-packet; no timeout.
- Single-beat packets (first beat carries tlast) are legal: LOCK lasts one accepted beat.
- Output stage is a 2-entry skid buffer:
  - A beat is stored with {tdata, tuser, tlast, tid}.
  - `m_axi_tvalid` is high while the skid holds at least one entry.
  - Entries drain on m_axi_tvalid && m_axi_tready.
  - `skid_full` means two entries are held.
  - Simultaneous push and pop keeps the count unchanged.
- `aclken`=0:
  - No register updates.
  - `s_axi_tready` is forced to 0.
  - Master outputs hold their values; no beat completes on either side.
- Reset values:
  - FSM = IDLE, `ptr` = NCH-1 (channel 0 has first priority).
  - Skid is empty.
  - `s_axi_tready`, `m_axi_tvalid`, `m_axi_tlast`, `m_axi_tuser`, `m_axi_tdata`, `m_axi_tid`, `grant_active`, `grant_idx` are all 0.
- Reset mid-packet:
  - The in-flight packet is discarded, including skid contents.
  - The downstream consumer sees `m_axi_tvalid` drop with no `tlast`. This is acceptable because reset is system-wide.
- NCH=1: the arbiter degenerates to always granting channel 0. The IDLE bubble remains.

## Timing
- Arbitration latency: valid seen at edge N-1, grant registered at edge N, first slave beat accepted at edge N+1 at the earliest.
- Data latency: a slave beat accepted at edge K gives `m_axi_tvalid`=1 with that beat after edge K.
- Within a packet: 1 beat/cycle while `m_axi_tready`=1.
- Between packets: exactly 1 idle cycle on the slave side; the skid hides it only while data is backlogged.
- `m_axi_tready` drop: at most one extra beat is absorbed. `s_axi_tready` falls the cycle after the skid becomes full.
- Master outputs are registered only. `s_axi_tready` depends combinationally only on registered state: FSM, grant, skid count.

## Configuration
- `AXIS_MUX_TID_EN` defined:
  - The `m_axi_tid` port exists.
  - Each skid entry carries a CHW-bit source index equal to `grant_idx` at the time of acceptance.
- Not defined: the port and the skid tid field are absent. All other behaviour is identical.

## Structure
- Package `axis_mux_pkg` holds:
  - the state enum `mux_state_e` {IDLE, LOCK};
  - the function `rr_pick(valid, ptr)`, which returns the winner index;
  - the function `clog2_min1`, used for CHW.
- Sub-module `axis_skid_buffer`:
  - Parametrised on payload width.
  - Instantiated once, with payload {tuser, tlast, tdata[, tid]}.
  - Reusable elsewhere in the stream fabric.

## Test plan
- **Reset and idle:** assert `areset` for 3 cycles with all valids high. During reset all outputs are 0. After release, the first grant goes to channel 0 (`grant_idx`=0).
- **Round-robin:** with NCH=4, keep channels 0–3 continuously valid with 2-beat packets. Output order is 0,1,2,3,0. Each packet's tdata arrives unmodified. There is one slave idle cycle between packets.
- **Packet lock:** start a channel 2 packet of 5 beats, drop valid after beat 2 for 4 cycles, and keep channel 1 valid. No channel 1 beat appears until channel 2's tlast beat. `s_axi_tready[1]` stays 0 throughout.
- **Backpressure:** hold `m_axi_tready`=0 for 10 cycles mid-packet. Exactly 2 beats are buffered and `s_axi_tready` drops. On release, the beats drain in order with no loss or duplication.
- **Clock enable:** pull `aclken` low for 3 cycles mid-packet. No handshake completes and the outputs hold. The packet then resumes intact.
- **TID (macro on):** run interleaved packets from channels 3 and 1. `m_axi_tid` equals 3 for every beat of the channel-3 packet and 1 for the channel-1 packet, including the final `tlast` beats.
